// File: rtl/student_dispatch4way.sv
// student_dispatch4way: valid/ready front end for a 4-way demultiplexer.
// One holding register sits between a single producer and four lane consumers.
// Lanes are picked round-robin among the enabled lanes. Fire and accept can
// happen in the same cycle, so a continuously ready lane sees one word per cycle.
// Optional feature macro: DISPATCH_STEER_EN. When it is defined, the lane is
// taken from in_dest instead of round-robin. A word bound for a disabled lane
// stalls at the input.
module student_dispatch4way #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       lane_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef DISPATCH_STEER_EN
    input  logic [1:0]       in_dest,
`endif
    output logic [WIDTH-1:0] out_data,
    output logic             a_valid,
    output logic             b_valid,
    output logic             c_valid,
    output logic             d_valid,
    input  logic             a_ready,
    input  logic             b_ready,
    input  logic             c_ready,
    input  logic             d_ready,
    output logic [1:0]       sel,
    output logic             busy,
    output logic [15:0]      deliver_count
);

    localparam int unsigned LANES   = 4;
    localparam int unsigned LANE_W  = 2;
    localparam int unsigned COUNT_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [WIDTH-1:0]    data_q;
    logic [LANE_W-1:0]   sel_q;
    logic [LANE_W-1:0]   last_q;
    logic [COUNT_W-1:0]  count_q;

    logic [LANES-1:0]    lane_ready;
    logic                fire;
    logic                accept;
    logic                target_ok;
    logic                can_take;
    logic [LANE_W-1:0]   pick;

    assign lane_ready = {d_ready, c_ready, b_ready, a_ready};

    // Fire: the held word is taken by its own lane; other lanes' readys are ignored.
    assign fire   = (state_q == HOLD) && lane_ready[sel_q];
    assign accept = in_valid && can_take;

`ifdef DISPATCH_STEER_EN
    // Steering: the producer names the lane. A word for a disabled lane stalls.
    always_comb begin
        pick      = in_dest;
        target_ok = lane_en[in_dest];
    end
`else
    logic rr_found;

    // Round-robin: take the first enabled lane after last, wrapping 3 to 0.
    always_comb begin
        pick     = '0;
        rr_found = 1'b0;
        for (int i = 1; i <= int'(LANES); i++) begin
            if (!rr_found && lane_en[LANE_W'(last_q + LANE_W'(i))]) begin
                pick     = LANE_W'(last_q + LANE_W'(i));
                rr_found = 1'b1;
            end
        end
        target_ok = |lane_en;
    end
`endif

    // The register can take a word when it is empty or is being emptied this cycle.
    always_comb begin
        can_take = ((state_q == EMPTY) || fire) && target_ok;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an accept always leaves the register full. A lone fire empties it.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = HOLD;
        end else if (fire) begin
            state_d = EMPTY;
        end
    end

    // Outputs: lane valids decode sel gated by busy, the same decode as dmux4way with in=busy.
    always_comb begin
        busy     = 1'b0;
        in_ready = 1'b0;
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        c_valid  = 1'b0;
        d_valid  = 1'b0;
        busy     = (state_q == HOLD);
        in_ready = can_take;
        a_valid  = busy && (sel_q == 2'd0);
        b_valid  = busy && (sel_q == 2'd1);
        c_valid  = busy && (sel_q == 2'd2);
        d_valid  = busy && (sel_q == 2'd3);
    end

    // Holding register and lane pointers. The data and sel values stay put after a fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            sel_q  <= '0;
            last_q <= LANE_W'(LANES - 1);
        end else if (accept) begin
            data_q <= in_data;
            sel_q  <= pick;
            last_q <= pick;
        end
    end

    // Delivered-word counter; it wraps at 2^16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (fire) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign out_data      = data_q;
    assign sel           = sel_q;
    assign deliver_count = count_q;

endmodule

// File: tb/tb_student_dispatch4way.sv
// Scoreboard bench for student_dispatch4way. An acceptor process models every
// input handshake and pushes the expected lane and data. A monitor process pops
// an entry whenever the held word fires and compares it against the DUT.
module tb_student_dispatch4way;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [3:0]       lane_en = 4'h0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
`ifdef DISPATCH_STEER_EN
    logic [1:0]       in_dest = 2'd0;
`endif
    logic [WIDTH-1:0] out_data;
    logic             a_valid, b_valid, c_valid, d_valid;
    logic [3:0]       rdy = 4'h0;
    logic [1:0]       sel;
    logic             busy;
    logic [15:0]      deliver_count;

    student_dispatch4way #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .lane_en(lane_en),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
`ifdef DISPATCH_STEER_EN
        .in_dest(in_dest),
`endif
        .out_data(out_data),
        .a_valid(a_valid),
        .b_valid(b_valid),
        .c_valid(c_valid),
        .d_valid(d_valid),
        .a_ready(rdy[0]),
        .b_ready(rdy[1]),
        .c_ready(rdy[2]),
        .d_ready(rdy[3]),
        .sel(sel),
        .busy(busy),
        .deliver_count(deliver_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          lane;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   fired[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   m_last  = 3;
    int   m_count = 0;

    // Acceptor model state
    logic a_ok, a_fire, a_exp_rdy, a_found;
    int   a_pick;
    // Monitor model state
    logic m_held;
    logic [3:0] m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] en, input logic [3:0] r);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        lane_en  = en;
        rdy      = r;
    endtask

    task automatic check_fired(input string name, input int exp_lanes[$]);
        check({name, "_n"}, 32'(fired.size()), 32'(exp_lanes.size()));
        for (int i = 0; i < exp_lanes.size(); i++) begin
            check({name, "_lane"}, (i < fired.size()) ? 32'(fired[i]) : 32'hFF, 32'(exp_lanes[i]));
        end
    endtask

    // Acceptor: predicts in_ready and records each accepted word with its lane.
    always @(negedge clk) begin
        #1;
        if (rst_n === 1'b1) begin
`ifdef DISPATCH_STEER_EN
            a_ok = lane_en[in_dest];
`else
            a_ok = (lane_en != 4'h0);
`endif
            a_fire    = (exp_q.size() > 0) && rdy[exp_q[0].lane];
            a_exp_rdy = ((exp_q.size() == 0) || a_fire) && a_ok;
            check("in_ready", 32'(in_ready), 32'(a_exp_rdy));
            if (in_valid && in_ready) begin
`ifdef DISPATCH_STEER_EN
                a_pick = int'(in_dest);
`else
                a_pick  = 0;
                a_found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    if (!a_found && lane_en[(m_last + k) % 4]) begin
                        a_pick  = (m_last + k) % 4;
                        a_found = 1'b1;
                    end
                end
`endif
                exp_q.push_back('{data: in_data, lane: a_pick, cyc: cyc});
                m_last = a_pick;
            end
        end
    end

    // Monitor: compares the held word and lane valids, and retires the word on fire.
    always @(negedge clk) begin
        #2;
        if (rst_n === 1'b1) begin
            m_held  = (exp_q.size() > 0) && (exp_q[0].cyc < cyc);
            m_valid = m_held ? 4'(1 << exp_q[0].lane) : 4'h0;
            check("lane_valid", 32'({d_valid, c_valid, b_valid, a_valid}), 32'(m_valid));
            check("busy", 32'(busy), 32'(m_held));
            check("deliver_count", 32'(deliver_count), 32'(m_count & 16'hFFFF));
            if (m_held) begin
                check("out_data", 32'(out_data), 32'(exp_q[0].data));
                check("sel", 32'(sel), 32'(exp_q[0].lane));
                if (rdy[exp_q[0].lane]) begin
                    fired.push_back(exp_q[0].lane);
                    void'(exp_q.pop_front());
                    m_count++;
                end
            end
            cyc++;
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valids", 32'({d_valid, c_valid, b_valid, a_valid}), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_count", 32'(deliver_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef DISPATCH_STEER_EN
        // Four back-to-back words spread over a, b, c, d.
        fired.delete();
        drive(1'b1, 16'h0011, 4'hF, 4'hF);
        drive(1'b1, 16'h0022, 4'hF, 4'hF);
        drive(1'b1, 16'h0033, 4'hF, 4'hF);
        drive(1'b1, 16'h0044, 4'hF, 4'hF);
        drive(1'b0, 16'h0000, 4'hF, 4'hF);
        drive(1'b0, 16'h0000, 4'hF, 4'hF);
        #3 check("t1_count", 32'(deliver_count), 32'd4);
        check_fired("t1", '{0, 1, 2, 3});

        // Only a and c enabled: the lanes alternate.
        fired.delete();
        for (int i = 0; i < 4; i++) drive(1'b1, 16'(16'h0100 + i), 4'b0101, 4'hF);
        drive(1'b0, 16'h0000, 4'b0101, 4'hF);
        drive(1'b0, 16'h0000, 4'b0101, 4'hF);
        check_fired("t2", '{0, 2, 0, 2});

        // Lane c stalls for five cycles, then fire and accept happen together.
        fired.delete();
        drive(1'b1, 16'h0C0C, 4'b0100, 4'b1011);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h0D0D, 4'hF, 4'b1011);
            #3;
            check("t3_c_valid", 32'(c_valid), 32'd1);
            check("t3_out_data", 32'(out_data), 32'h0C0C);
            check("t3_in_ready", 32'(in_ready), 32'd0);
        end
        drive(1'b1, 16'h0D0D, 4'hF, 4'hF);
        #3 check("t3_fire_accept", 32'(in_ready), 32'd1);
        drive(1'b0, 16'h0000, 4'hF, 4'hF);
        drive(1'b0, 16'h0000, 4'hF, 4'hF);
        check_fired("t3", '{2, 3});

        // No lane enabled: the word waits until d is enabled.
        fired.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0E0E, 4'h0, 4'hF);
            #3;
            check("t4_in_ready", 32'(in_ready), 32'd0);
            check("t4_busy", 32'(busy), 32'd0);
        end
        drive(1'b1, 16'h0E0E, 4'b1000, 4'hF);
        drive(1'b0, 16'h0000, 4'b1000, 4'hF);
        drive(1'b0, 16'h0000, 4'b1000, 4'hF);
        check_fired("t4", '{3});
`else
        // Steering: a word for disabled lane c stalls, then a word for d is delivered.
        fired.delete();
        in_dest = 2'b10;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h5050, 4'b1011, 4'hF);
            #3;
            check("s_in_ready", 32'(in_ready), 32'd0);
            check("s_busy", 32'(busy), 32'd0);
        end
        in_dest = 2'b11;
        drive(1'b1, 16'h5151, 4'b1011, 4'hF);
        drive(1'b0, 16'h0000, 4'b1011, 4'hF);
        drive(1'b0, 16'h0000, 4'b1011, 4'hF);
        check_fired("s1", '{3});
        in_dest = 2'b01;
`endif

        // Asynchronous reset while b holds a word.
        drive(1'b1, 16'h0B0B, 4'b0010, 4'h0);
        drive(1'b0, 16'h0000, 4'b0010, 4'h0);
        #3 check("t5_b_valid_pre", 32'(b_valid), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        fired.delete();
        m_last  = 3;
        m_count = 0;
        #1;
        check("t5_b_valid", 32'(b_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_count", 32'(deliver_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef DISPATCH_STEER_EN
        in_dest = 2'b00;
`endif
        drive(1'b1, 16'h0A0A, 4'hF, 4'hF);
        drive(1'b0, 16'h0000, 4'hF, 4'hF);
        drive(1'b0, 16'h0000, 4'hF, 4'hF);
        check_fired("t5", '{0});

        // Random traffic with occasional mask changes and random lane readys.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) lane_en = 4'($urandom);
            rdy = 4'($urandom);
`ifdef DISPATCH_STEER_EN
            in_dest = 2'($urandom);
`endif
        end

        // Drain with every lane ready.
        drive(1'b0, 16'h0000, lane_en, 4'hF);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
